// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a multiplexed 7-segment scan bus (active-low enables/segments).
// Debounces each digit dwell, decodes segments to hex nibbles and assembles 8-digit frames.
module seg_scan_decoder #(
   parameter int unsigned SETTLE  = 2,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  led_en,
   input  logic [7:0]  led_cx,
   output logic [63:0] values,
   output logic [7:0]  dp,
   output logic [7:0]  blank,
   output logic [7:0]  invalid,
   output logic        frame_valid,
   output logic        multi_en_err,
   output logic        idle
);

   localparam int unsigned IW = $clog2(TIMEOUT + 1);
   localparam logic [IW-1:0] TO_MAX    = IW'(TIMEOUT);
   localparam logic [7:0]    SETTLE_M1 = 8'(SETTLE - 1);

   typedef struct packed {
      logic [3:0] nib;
      logic       dp;
      logic       blank;
      logic       inv;
   } digit_t;

   localparam digit_t DIGIT_RST = '{nib: 4'h0, dp: 1'b0, blank: 1'b1, inv: 1'b0};

   function automatic digit_t decode_cx(input logic [7:0] cx);
      digit_t     d;
      logic [6:0] pat;
      pat = ~cx[6:0];
      d   = '{nib: 4'h0, dp: ~cx[7], blank: 1'b0, inv: 1'b0};
      case (pat)
         7'h3F:   d.nib = 4'h0;
         7'h06:   d.nib = 4'h1;
         7'h5B:   d.nib = 4'h2;
         7'h4F:   d.nib = 4'h3;
         7'h66:   d.nib = 4'h4;
         7'h6D:   d.nib = 4'h5;
         7'h7D:   d.nib = 4'h6;
         7'h07:   d.nib = 4'h7;
         7'h7F:   d.nib = 4'h8;
         7'h67:   d.nib = 4'h9;
         7'h77:   d.nib = 4'hA;
         7'h7C:   d.nib = 4'hB;
         7'h58:   d.nib = 4'hC;
         7'h5E:   d.nib = 4'hD;
         7'h79:   d.nib = 4'hE;
         7'h71:   d.nib = 4'hF;
         7'h00:   d.blank = 1'b1;
         default: d.inv = 1'b1;
      endcase
      return d;
   endfunction

   // sample stage
   logic [7:0] en_s, cx_s;

   // previous sample for the stability compare
   logic [7:0] cx_p;
   logic [2:0] idx_p;
   logic       dig_p;

   logic [7:0]    cnt_q;
   logic          done_q;
   logic [7:0]    seen;
   logic          frame_go;
   logic [IW-1:0] idle_cnt;
   digit_t        shadow [8];

   // enable decode of the registered sample
   logic [2:0] idx;
   logic [3:0] zeros;
   logic       dig, multi;

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      idx   = 3'd0;
      zeros = 4'd0;
      for (int i = 0; i < 8; i++) begin
         if (!en_s[i]) begin
            zeros = zeros + 4'd1;
            idx   = 3'(i);
         end
      end
      dig   = (zeros == 4'd1);
      multi = (zeros > 4'd1);
   end

   // stability filter and capture decision
   logic          eq, done_eff, capture, timeout_hit;
   logic [7:0]    run, seen_or;
   logic [IW-1:0] idle_nxt;

   always_comb begin
      eq       = dig && dig_p && (idx == idx_p) && (cx_s == cx_p);
      run      = 8'd0;
      if (eq) run = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      done_eff = eq && done_q;
      capture  = dig && (run >= SETTLE_M1) && !done_eff;
      seen_or  = seen;
      if (capture) seen_or = seen | (8'd1 << idx);
      idle_nxt = idle_cnt;
      if (dig) idle_nxt = '0;
      else if (idle_cnt != TO_MAX) idle_nxt = idle_cnt + 1'b1;
      timeout_hit = !dig && (idle_cnt == TO_MAX - 1'b1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments only.
         en_s <= 8'hFF;
         cx_s <= 8'hFF;
      end else begin
         en_s <= led_en;
         cx_s <= led_cx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cx_p         <= 8'hFF;
         idx_p        <= 3'd0;
         dig_p        <= 1'b0;
         cnt_q        <= 8'd0;
         done_q       <= 1'b0;
         seen         <= 8'd0;
         frame_go     <= 1'b0;
         idle_cnt     <= '0;
         values       <= 64'd0;
         dp           <= 8'd0;
         blank        <= 8'hFF;
         invalid      <= 8'd0;
         frame_valid  <= 1'b0;
         multi_en_err <= 1'b0;
         idle         <= 1'b1;
         // NOTE: the shadow bank is reset so a partial frame can never leak out after reset.
         for (int i = 0; i < 8; i++) shadow[i] <= DIGIT_RST;
      end else begin
         cx_p         <= cx_s;
         idx_p        <= idx;
         dig_p        <= dig;
         cnt_q        <= run;
         done_q       <= capture || done_eff;
         idle_cnt     <= idle_nxt;
         multi_en_err <= multi;
         frame_valid  <= 1'b0;

         if (capture) shadow[idx] <= decode_cx(cx_s);

         if (timeout_hit) begin
            idle     <= 1'b1;
            seen     <= 8'd0;
            frame_go <= 1'b0;
            values   <= 64'd0;
            dp       <= 8'd0;
            blank    <= 8'hFF;
            invalid  <= 8'd0;
         end else begin
            if (capture) idle <= 1'b0;
            // clearing seen here lets a capture on the publish cycle count toward the next frame
            seen     <= (seen_or == 8'hFF) ? 8'd0 : seen_or;
            frame_go <= (seen_or == 8'hFF);
            if (frame_go) begin
               frame_valid <= 1'b1;
               for (int i = 0; i < 8; i++) begin
                  values[8*i +: 8] <= {4'h0, shadow[i].nib};
                  dp[i]            <= shadow[i].dp;
                  blank[i]         <= shadow[i].blank;
                  invalid[i]       <= shadow[i].inv;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed testbench for seg_scan_decoder with SETTLE=2 and TIMEOUT=16.
module tb_seg_scan_decoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  led_en = 8'hFF;
   logic [7:0]  led_cx = 8'hFF;
   logic [63:0] values;
   logic [7:0]  dp, blank, invalid;
   logic        frame_valid, multi_en_err, idle;

   int checks = 0;
   int errors = 0;
   int fv_cnt = 0;
   int mee_cnt = 0;

   seg_scan_decoder #(.SETTLE(2), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .led_en(led_en), .led_cx(led_cx),
      .values(values), .dp(dp), .blank(blank), .invalid(invalid),
      .frame_valid(frame_valid), .multi_en_err(multi_en_err), .idle(idle)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      if (frame_valid) fv_cnt++;
      if (multi_en_err) mee_cnt++;
   end

   function automatic logic [7:0] enc(input logic [3:0] n);
      logic [6:0] p;
      case (n)
         4'h0: p = 7'h3F; 4'h1: p = 7'h06; 4'h2: p = 7'h5B; 4'h3: p = 7'h4F;
         4'h4: p = 7'h66; 4'h5: p = 7'h6D; 4'h6: p = 7'h7D; 4'h7: p = 7'h07;
         4'h8: p = 7'h7F; 4'h9: p = 7'h67; 4'hA: p = 7'h77; 4'hB: p = 7'h7C;
         4'hC: p = 7'h58; 4'hD: p = 7'h5E; 4'hE: p = 7'h79; default: p = 7'h71;
      endcase
      return {1'b1, ~p};
   endfunction

   task automatic drive(input int idx, input logic [7:0] cx, input int n);
      repeat (n) begin
         @(negedge clk);
         led_en = ~(8'd1 << idx);
         led_cx = cx;
      end
   endtask

   task automatic idle_bus(input int n);
      repeat (n) begin
         @(negedge clk);
         led_en = 8'hFF;
         led_cx = 8'hFF;
      end
   endtask

   task automatic scan(input logic [63:0] v);
      for (int i = 0; i < 8; i++) drive(i, enc(v[8*i +: 4]), 6);
      idle_bus(2);
   endtask

   task automatic expect_frame(input string name, input logic [63:0] v, input logic [7:0] b,
                               input logic [7:0] inv, input logic [7:0] d);
      checks++;
      if (values !== v) begin
         errors++;
         $display("FAIL %s values: got %h expected %h", name, values, v);
      end
      checks++;
      if (blank !== b || invalid !== inv || dp !== d) begin
         errors++;
         $display("FAIL %s flags: got blank=%h invalid=%h dp=%h expected blank=%h invalid=%h dp=%h",
                  name, blank, invalid, dp, b, inv, d);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({values, dp, blank, invalid, frame_valid, multi_en_err, idle} !==
          {64'd0, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset: got values=%h dp=%h blank=%h invalid=%h fv=%b mee=%b idle=%b expected 0/00/FF/00/0/0/1",
                  values, dp, blank, invalid, frame_valid, multi_en_err, idle);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_latency;
      logic got;
      for (int i = 0; i < 7; i++) drive(i, enc(4'(i)), 6);
      @(negedge clk);
      led_en = 8'h7F;
      led_cx = enc(4'h7);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         got = frame_valid;
         checks++;
         if (got !== (k == 4)) begin
            errors++;
            $display("FAIL latency cycle %0d: frame_valid=%b expected %b", k, got, (k == 4));
         end
      end
      checks++;
      if (idle !== 1'b0) begin
         errors++;
         $display("FAIL latency idle: got %b expected 0", idle);
      end
      expect_frame("latency", 64'h0706_0504_0302_0100, 8'h00, 8'h00, 8'h00);
      idle_bus(2);
   endtask

   task automatic test_frame;
      int fv0;
      fv0 = fv_cnt;
      scan(64'h0100_0200_0006_0109);
      scan(64'h0100_0200_0006_0109);
      checks++;
      if (fv_cnt - fv0 != 2) begin
         errors++;
         $display("FAIL frame count: got %0d expected 2", fv_cnt - fv0);
      end
      expect_frame("frame", 64'h0100_0200_0006_0109, 8'h00, 8'h00, 8'h00);
   endtask

   task automatic test_glitch;
      int fv0;
      fv0 = fv_cnt;
      drive(0, enc(4'h8), 6);
      drive(1, enc(4'h9), 6);
      drive(2, enc(4'h0), 6);
      drive(3, enc(4'h5), 1);
      drive(3, 8'h00, 1);
      drive(3, enc(4'h5), 4);
      drive(4, enc(4'hB), 6);
      drive(5, enc(4'hC), 6);
      drive(6, enc(4'hD), 6);
      drive(7, enc(4'hE), 6);
      idle_bus(2);
      checks++;
      if (fv_cnt - fv0 != 1) begin
         errors++;
         $display("FAIL glitch count: got %0d expected 1", fv_cnt - fv0);
      end
      expect_frame("glitch", 64'h0E0D_0C0B_0500_0908, 8'h00, 8'h00, 8'h00);
   endtask

   task automatic test_multi;
      int fv0, m0;
      fv0 = fv_cnt;
      m0  = mee_cnt;
      for (int i = 0; i < 4; i++) drive(i, enc(4'(8 - i)), 6);
      @(negedge clk);
      led_en = 8'b1111_1100;
      led_cx = 8'hFF;
      for (int i = 4; i < 8; i++) drive(i, enc(4'(8 - i)), 6);
      idle_bus(2);
      checks++;
      if (mee_cnt - m0 != 1) begin
         errors++;
         $display("FAIL multi pulses: got %0d expected 1", mee_cnt - m0);
      end
      scan(64'h0102_0304_0506_0708);
      checks++;
      if (fv_cnt - fv0 != 2) begin
         errors++;
         $display("FAIL multi frame count: got %0d expected 2", fv_cnt - fv0);
      end
      expect_frame("multi", 64'h0102_0304_0506_0708, 8'h00, 8'h00, 8'h00);
   endtask

   task automatic test_blank_invalid_dp;
      drive(0, 8'h40, 6);
      drive(1, enc(4'h1), 6);
      drive(2, 8'hB6, 6);
      drive(3, enc(4'h3), 6);
      drive(4, enc(4'h4), 6);
      drive(5, 8'hFF, 6);
      drive(6, enc(4'h6), 6);
      drive(7, enc(4'h7), 6);
      idle_bus(2);
      expect_frame("blank_inv_dp", 64'h0706_0004_0300_0100, 8'h20, 8'h04, 8'h01);
   endtask

   task automatic test_idle;
      int fv0;
      scan(64'h0100_0200_0006_0109);
      checks++;
      if (idle !== 1'b0) begin
         errors++;
         $display("FAIL idle before timeout: got %b expected 0", idle);
      end
      fv0 = fv_cnt;
      idle_bus(20);
      checks++;
      if (idle !== 1'b1 || fv_cnt != fv0) begin
         errors++;
         $display("FAIL idle timeout: idle=%b frames=%0d expected idle=1 frames=0", idle, fv_cnt - fv0);
      end
      expect_frame("idle_clear", 64'd0, 8'hFF, 8'h00, 8'h00);
      scan(64'h0100_0200_0006_0109);
      checks++;
      if (idle !== 1'b0 || fv_cnt - fv0 != 1) begin
         errors++;
         $display("FAIL idle recovery: idle=%b frames=%0d expected idle=0 frames=1", idle, fv_cnt - fv0);
      end
      expect_frame("idle_recover", 64'h0100_0200_0006_0109, 8'h00, 8'h00, 8'h00);
   endtask

   task automatic test_reset_mid_frame;
      int fv0;
      for (int i = 0; i < 4; i++) drive(i, enc(4'hA), 6);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({values, dp, blank, invalid, frame_valid, multi_en_err, idle} !==
          {64'd0, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset mid-frame: got values=%h dp=%h blank=%h invalid=%h fv=%b mee=%b idle=%b expected 0/00/FF/00/0/0/1",
                  values, dp, blank, invalid, frame_valid, multi_en_err, idle);
      end
      @(negedge clk);
      rst_n = 1'b1;
      fv0 = fv_cnt;
      for (int i = 0; i < 7; i++) drive(i, enc(4'(i + 3)), 6);
      checks++;
      if (fv_cnt != fv0) begin
         errors++;
         $display("FAIL reset early frame: got %0d frames expected 0", fv_cnt - fv0);
      end
      drive(7, enc(4'hA), 6);
      idle_bus(2);
      checks++;
      if (fv_cnt - fv0 != 1) begin
         errors++;
         $display("FAIL reset frame count: got %0d expected 1", fv_cnt - fv0);
      end
      expect_frame("reset_mid", 64'h0A09_0807_0605_0403, 8'h00, 8'h00, 8'h00);
   endtask

   initial begin
      test_reset;
      test_latency;
      test_frame;
      test_glitch;
      test_multi;
      test_blank_invalid_dp;
      test_idle;
      test_reset_mid_frame;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
Receive-side decoder for the multiplexed 7-segment scan bus that the display drivers emit: active-low digit enables and active-low segment lines.
- Samples the bus and debounces scan transitions.
- Decodes each digit's segment pattern back to a hex nibble and assembles complete 8-digit frames.
- Used as the on-chip loopback/monitor for display blocks and as the checker inside display testbenches.

Parameters:
SETTLE, 2, consecutive cycles an (enable, segment) pair must be unchanged before it is captured; legal range 1..255.
TIMEOUT, 1024, consecutive cycles with no digit enabled before the scan is declared idle; legal range 2..2^20.

Ports:
clk  in  1  system clock; one clock domain.
rst_n  in  1  reset; asynchronous, active-low.
led_en  in  8  digit enables, active-low, bit i = digit i.
led_cx  in  8  segments, active-low, {dp,g,f,e,d,c,b,a}.
values  out  64  decoded frame, byte i = {4'h0, nibble of digit i}.
dp  out  8  decimal-point state per digit (1 = lit).
blank  out  8  1 = digit captured with all segments off.
invalid  out  8  1 = digit captured with an undecodable pattern.
frame_valid  out  1  one-cycle pulse; outputs updated this cycle.
multi_en_err  out  1  one-cycle pulse; more than one enable low in a sample.
idle  out  1  level; scan stopped (TIMEOUT reached).

Behaviour:
- Reset (async assert, sync release) clears:
  - Outputs: values=0, dp=0, blank=8'hFF, invalid=0, frame_valid=0, multi_en_err=0, idle=1.
  - Internal: seen mask, shadow registers, stable counter and idle counter.
- Inputs are registered once (sample stage); all decoding uses the registered copy.
- Enable decode per sample:
  - Exactly one bit low: idx = that bit.
  - All high: no digit.
  - More than one low: multi_en_err=1 next cycle; the sample is treated as no digit.
- Stability filter:
  - Compare the current {idx, cx} with the previous sample.
  - Equal and a digit is enabled: stable counter increments, saturating.
  - Otherwise: counter resets to 0 and the capture-done flag is cleared.
- Capture happens when the pair has been identical for SETTLE consecutive samples and capture-done is clear. On capture:
  - Write shadow[idx]; set seen[idx]; set capture-done.
  - Exactly one capture per dwell.
  - A later dwell on the same idx overwrites shadow[idx].
- Segment decode (active-high pattern = ~cx[6:0], listed as gfedcba):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:67, A:77, B:7C, C:58, D:5E, E:79, F:71
  - 00: blank=1, nibble=0.
  - Any other pattern: invalid=1, nibble=0.
  - dp = ~cx[7], independent of the nibble decode.
- Frame completion: the cycle after the capture that makes seen==8'hFF:
  - Copy all shadows to values/dp/blank/invalid and pulse frame_valid.
  - Clear seen.
  - A capture in that same cycle counts toward the next frame.
- Latency, from the first bus cycle of a digit's final stable value:
  - Capture at SETTLE+1 cycles (input register + filter).
  - frame_valid 1 cycle after the 8th capture.
- Idle:
  - The idle counter counts samples with no digit enabled and resets on any enabled sample.
  - At TIMEOUT: idle=1, seen cleared, values=0, blank=8'hFF, dp=0, invalid=0; no frame_valid.
  - idle drops on the first capture.
- multi_en_err and frame_valid may assert in the same cycle.
- Reset mid-frame discards partial shadows; no pulse is emitted.

Test Plan:
- Frame decode: drive a scan of values 64'h0100_0200_0006_0109, 6 cycles per digit, digits 0..7 in order. Required: frame_valid pulses once per scan, values=64'h0100_0200_0006_0109, blank=0, invalid=0, dp=0.
- Glitch rejection: SETTLE=2, 1-cycle segment glitch (cx=8'h00) inside digit 3's dwell. Required: digit 3 still decodes to its steady value; no invalid bit set.
- Multi-enable: one cycle with led_en=8'b1111_1100. Required: multi_en_err pulses exactly once; that sample produces no capture; the frame still completes on the next full scan.
- Blank/invalid/dp: digit 5 with cx=8'hFF, digit 2 with cx=~8'h49, digit 0 with cx=~8'hBF. Required:
  - blank=8'h20, invalid=8'h04, dp=8'h01.
  - byte0=8'h00, byte2=8'h00, byte5=8'h00.
- Idle timeout: TIMEOUT=16, led_en=8'hFF for 16 cycles after a valid frame. Required: idle=1, values=0, blank=8'hFF; the next full scan gives frame_valid and idle=0.
- Reset mid-frame: rst_n low after 4 digits, then a full scan. Required: all outputs at reset values immediately; exactly one frame_valid, after all 8 post-reset captures.
